// File: rtl/sel_arbiter.sv
// Two-requester arbiter for a shared 2:1 selector with round-robin tie-break,
// a bounded hold time under contention, and a one-cycle gap between owners.
module sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic       A,
    input  logic       B,
    output logic       SEL,
    output logic       Q,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       PREEMPT,
    output logic [1:0] DBG_STATE
);

    // Handshake: REQ_x is a level request sampled every edge; GNT_x rises the
    // cycle after the winning edge and stays high until REQ_x is sampled low
    // or the hold budget expires with the other side waiting.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             q_q, q_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             preempt_q, preempt_d;
    logic             last_a_q, last_a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        last_a_d  = last_a_q;
        preempt_d = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                // On a tie, the side that was not served last wins
                if (REQ_A && (!REQ_B || !last_a_q)) begin
                    state_d  = OWN_A;
                    last_a_d = 1'b1;
                    cnt_d    = '0;
                end else if (REQ_B) begin
                    state_d  = OWN_B;
                    last_a_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            OWN_A: begin
                q_d = A;
                if (!REQ_A) begin
                    state_d = GAP;
                end else if (REQ_B && (cnt_q == HOLD_LAST)) begin
                    state_d   = GAP;
                    preempt_d = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OWN_B: begin
                q_d = B;
                if (!REQ_B) begin
                    state_d = GAP;
                end else if (REQ_A && (cnt_q == HOLD_LAST)) begin
                    state_d   = GAP;
                    preempt_d = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
        // Selector keeps pointing at the previous owner through IDLE and GAP
        if (state_d == OWN_A) begin
            sel_d = 1'b1;
        end else if (state_d == OWN_B) begin
            sel_d = 1'b0;
        end else begin
            sel_d = sel_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            q_q       <= 1'b0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            preempt_q <= 1'b0;
            last_a_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            q_q       <= q_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            preempt_q <= preempt_d;
            last_a_q  <= last_a_d;
            cnt_q     <= cnt_d;
        end
    end

    assign SEL       = sel_q;
    assign Q         = q_q;
    assign GNT_A     = gnt_a_q;
    assign GNT_B     = gnt_b_q;
    assign PREEMPT   = preempt_q;
    assign DBG_STATE = state_q;

endmodule
